edge_detect_multi: RTL

EDGE_DETECT_MULTI -- requirements
Module: edge_detect_multi

---
 rtl/edge_detect_multi_if.sv | 45 ++++
 rtl/edge_detect_multi.sv | 118 +++++++++++
 2 files changed

// File: rtl/edge_detect_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_multi_if
// Description : Channel bundle for edge_detect_multi: raw inputs, per-channel
//               mode/clear controls and the pulse/flag outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface edge_detect_multi_if #(
    parameter int CH = 4
);
    logic [CH-1:0]   rx_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   clr;
    logic [CH-1:0]   pos_pulse;
    logic [CH-1:0]   neg_pulse;
    logic [CH-1:0]   doub_pulse;
    logic [CH-1:0]   irq_flag;
    logic [CH-1:0]   ovf_flag;
    logic            irq;

    modport master (
        output rx_in,
        output mode,
        output clr,
        input  pos_pulse,
        input  neg_pulse,
        input  doub_pulse,
        input  irq_flag,
        input  ovf_flag,
        input  irq
    );

    modport slave (
        input  rx_in,
        input  mode,
        input  clr,
        output pos_pulse,
        output neg_pulse,
        output doub_pulse,
        output irq_flag,
        output ovf_flag,
        output irq
    );
endinterface
`default_nettype wire

// File: rtl/edge_detect_multi.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect_multi
// Description : Multi-channel synchronised, glitch-filtered edge detector with
//               per-channel edge pulses, sticky event/overflow flags and irq.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst,
    edge_detect_multi_if.slave bus
);

    localparam int                 c_CNT_W    = $clog2(FILT_LEN + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILT_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    wire [CH-1:0] w_sync_q;
    wire [CH-1:0] w_filt_q;
    wire [CH-1:0] w_pos;
    wire [CH-1:0] w_neg;
    wire [CH-1:0] w_doub;
    wire [CH-1:0] w_irq_flag;
    wire [CH-1:0] w_ovf_flag;

    generate
        for (genvar i = 0; i < CH; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] r_sync;
            logic [c_CNT_W-1:0]     r_cnt;
            logic                   r_filt;
            logic                   r_filt_d;
            logic                   r_pos;
            logic                   r_neg;
            logic                   r_doub;
            logic                   r_irq_flag;
            logic                   r_ovf_flag;
            logic                   w_event;

            // Bit 0 is the metastability-catching stage; the MSB feeds the filter.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync <= '0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], bus.rx_in[i]};
                end
            end

            assign w_sync_q[i] = r_sync[SYNC_STAGES-1];

            // The counter measures how long the synchronised level has differed
            // from the accepted level; any return to agreement restarts it.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt  <= '0;
                    r_filt <= 1'b0;
                end else if (w_sync_q[i] == r_filt) begin
                    r_cnt  <= '0;
                end else if (r_cnt == c_CNT_LAST) begin
                    r_filt <= w_sync_q[i];
                    r_cnt  <= '0;
                end else begin
                    r_cnt  <= r_cnt + c_CNT_ONE;
                end
            end

            assign w_filt_q[i] = r_filt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_filt_d <= 1'b0;
                    r_pos    <= 1'b0;
                    r_neg    <= 1'b0;
                    r_doub   <= 1'b0;
                end else begin
                    r_filt_d <= r_filt;
                    r_pos    <= r_filt & ~r_filt_d;
                    r_neg    <= ~r_filt & r_filt_d;
                    r_doub   <= r_filt ^ r_filt_d;
                end
            end

            // Mode is applied to the pulse currently on the outputs, so a new
            // mode affects the first pulse following the edge that samples it.
            assign w_event = (r_pos & bus.mode[2*i]) | (r_neg & bus.mode[2*i+1]);

            // Clear never suppresses a coincident event on irq_flag, but it
            // always wins on ovf_flag.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_irq_flag <= 1'b0;
                    r_ovf_flag <= 1'b0;
                end else begin
                    r_irq_flag <= w_event | (r_irq_flag & ~bus.clr[i]);
                    r_ovf_flag <= ~bus.clr[i] & (r_ovf_flag | (w_event & r_irq_flag));
                end
            end

            assign w_pos[i]      = r_pos;
            assign w_neg[i]      = r_neg;
            assign w_doub[i]     = r_doub;
            assign w_irq_flag[i] = r_irq_flag;
            assign w_ovf_flag[i] = r_ovf_flag;
        end
    endgenerate

    assign bus.pos_pulse  = w_pos;
    assign bus.neg_pulse  = w_neg;
    assign bus.doub_pulse = w_doub;
    assign bus.irq_flag   = w_irq_flag;
    assign bus.ovf_flag   = w_ovf_flag;
    assign bus.irq        = |w_irq_flag;

endmodule
`default_nettype wire
